// File: rtl/vdp_cpu_port.sv
// CPU port controller for a TMS9918-style VDP: control/data port decode, register
// file, auto-incrementing VRAM address, read-ahead buffer and status/interrupt.
`timescale 1ns/1ps
module vdp_cpu_port #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 io_wr,
    input  logic                 io_rd,
    input  logic                 port_sel,
    input  logic [7:0]           din,
    output logic [7:0]           dout,
    output logic [ADDR_BITS-1:0] vram_addr,
    output logic                 vram_wr,
    output logic [7:0]           vram_wdata,
    output logic                 vram_rd,
    input  logic [7:0]           vram_rdata,
    input  logic                 frame_pulse,
    input  logic                 coll_pulse,
    input  logic                 fifth_pulse,
    input  logic [4:0]           fifth_num,
    output logic [63:0]          regs,
    output logic                 int_n,
    output logic                 overrun
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT} state_e;

    state_e               state_q, state_d;
    logic [7:0][7:0]      regs_q, regs_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]           rbuf_q, rbuf_d;
    logic [7:0]           latch_q, latch_d;
    logic [7:0]           vram_wdata_q, vram_wdata_d;
    logic                 second_q, second_d;
    logic                 vram_wr_q, vram_wr_d;
    logic                 vram_rd_q, vram_rd_d;
    logic                 overrun_q, overrun_d;
    logic                 f_q, f_d, s5_q, s5_d, c_q, c_d;
    logic [4:0]           num_q, num_d;

    logic                 busy;
    logic                 stat_rd;
    logic                 pf_go;
    logic [ADDR_BITS-1:0] pf_base;
    logic [ADDR_BITS-1:0] ctl_addr;

    assign busy     = (state_q != IDLE);
    assign stat_rd  = io_rd & port_sel;
    assign ctl_addr = ADDR_BITS'({din[5:0], latch_q});

    always_comb begin
        // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latches).
        state_d      = state_q;
        regs_d       = regs_q;
        addr_d       = addr_q;
        vram_addr_d  = vram_addr_q;
        rbuf_d       = rbuf_q;
        latch_d      = latch_q;
        vram_wdata_d = vram_wdata_q;
        second_d     = second_q;
        vram_wr_d    = 1'b0;
        vram_rd_d    = 1'b0;
        overrun_d    = overrun_q;
        pf_go        = 1'b0;
        pf_base      = addr_q;

        case (state_q)
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                rbuf_d  = vram_rdata;
                state_d = IDLE;
            end
            default: ;
        endcase

        if (io_wr && port_sel) begin
            if (!second_q) begin
                latch_d  = din;
                second_d = 1'b1;
            end else if (din[7]) begin
                second_d = 1'b0;
                if (din[6:3] == 4'd0) regs_d[din[2:0]] = latch_q;
            end else if (din[6]) begin
                second_d = 1'b0;
                addr_d   = ctl_addr;
            end else if (busy) begin
                overrun_d = 1'b1;
            end else begin
                second_d = 1'b0;
                pf_go    = 1'b1;
                pf_base  = ctl_addr;
            end
        end else if (io_wr) begin
            if (busy) begin
                overrun_d = 1'b1;
            end else begin
                vram_addr_d  = addr_q;
                vram_wdata_d = din;
                vram_wr_d    = 1'b1;
                rbuf_d       = din;
                addr_d       = addr_q + ADDR_BITS'(1);
                second_d     = 1'b0;
            end
        end else if (io_rd && !port_sel) begin
            if (busy) begin
                overrun_d = 1'b1;
            end else begin
                second_d = 1'b0;
                pf_go    = 1'b1;
            end
        end else if (stat_rd) begin
            second_d = 1'b0;
        end

        // The read strobe leaves this cycle; the data is captured in RD_WAIT.
        if (pf_go) begin
            vram_addr_d = pf_base;
            addr_d      = pf_base + ADDR_BITS'(1);
            vram_rd_d   = 1'b1;
            state_d     = RD_REQ;
        end

        f_d   = (f_q  & ~stat_rd) | frame_pulse;
        c_d   = (c_q  & ~stat_rd) | coll_pulse;
        s5_d  = (s5_q & ~stat_rd) | fifth_pulse;
        num_d = (fifth_pulse && !s5_q) ? fifth_num : num_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; all decisions live in the comb block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            regs_q       <= '0;
            addr_q       <= '0;
            vram_addr_q  <= '0;
            rbuf_q       <= '0;
            latch_q      <= '0;
            vram_wdata_q <= '0;
            second_q     <= 1'b0;
            vram_wr_q    <= 1'b0;
            vram_rd_q    <= 1'b0;
            overrun_q    <= 1'b0;
            f_q          <= 1'b0;
            s5_q         <= 1'b0;
            c_q          <= 1'b0;
            num_q        <= '0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            addr_q       <= addr_d;
            vram_addr_q  <= vram_addr_d;
            rbuf_q       <= rbuf_d;
            latch_q      <= latch_d;
            vram_wdata_q <= vram_wdata_d;
            second_q     <= second_d;
            vram_wr_q    <= vram_wr_d;
            vram_rd_q    <= vram_rd_d;
            overrun_q    <= overrun_d;
            f_q          <= f_d;
            s5_q         <= s5_d;
            c_q          <= c_d;
            num_q        <= num_d;
        end
    end

    assign dout       = port_sel ? {f_q, s5_q, c_q, num_q} : rbuf_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wr    = vram_wr_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_rd    = vram_rd_q;
    assign regs       = regs_q;
    assign int_n      = ~(f_q & regs_q[1][5]);
    assign overrun    = overrun_q;
endmodule
